// File: rtl/bexp_y_tracker.sv
// bexp_y_tracker
// Watches the Y output of boolean_exp. It samples Y, generates registered
// rise/fall pulses and counts rising edges. It also measures every high run
// and hands each completed run length to a sink over a valid/ready handshake.
// Alongside that it keeps the longest run seen and a sticky overflow flag for
// runs that were lost because the sink stalled.
//
// Optional build macro: BEXP_TRACK_SYNC_EN
//   defined   -> y_in goes through a 2-flop synchronizer (2 extra cycles)
//   undefined -> y_in is used directly (source assumed synchronous to clk)
//
// Report handshake: rpt_valid rises with a stable rpt_len. Both hold until a
// clk edge where rpt_ready=1, and at that edge the report is consumed.
// rpt_ready is ignored while rpt_valid=0.
//
// state_dbg exposes the FSM state: 0=IDLE, 1=HIGH, 2=REPORT.

module bexp_y_tracker #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             y_in,
    input  logic             clr,
    output logic             y_q,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [LEN_W-1:0] run_len,
    output logic [LEN_W-1:0] max_len,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [LEN_W-1:0] rpt_len,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state;

    // Value of Y seen by all downstream logic.
    logic y_s;

`ifdef BEXP_TRACK_SYNC_EN
    logic sync_1;
    logic sync_2;

    // Two-flop synchronizer. It runs every cycle, regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= y_in;
            sync_2 <= sync_1;
        end
    end

    assign y_s = sync_2;
`else
    assign y_s = y_in;
`endif

    // Edge detection against the previous enabled sample.
    logic rise;
    logic fall;

    assign rise = en &  y_s & ~y_q;
    assign fall = en & ~y_s &  y_q;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    // Sample register and the registered one-cycle edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q        <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            if (en) begin
                y_q <= y_s;
            end
            rise_pulse <= rise;
            fall_pulse <= fall;
        end
    end

    // Run-measurement FSM. It owns run_len and the report registers.
    // The handshake in REPORT completes on rpt_ready even when en=0, so the
    // sink is never held waiting on the sampling enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run_len   <= '0;
            rpt_valid <= 1'b0;
            rpt_len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= HIGH;
                        run_len <= LEN_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        rpt_len   <= run_len;
                        rpt_valid <= 1'b1;
                        state     <= REPORT;
                    end else if (en && y_s) begin
                        if (run_len != LEN_MAX) begin
                            run_len <= run_len + LEN_ONE;
                        end
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        if (rise) begin
                            state   <= HIGH;
                            run_len <= LEN_ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Statistics: event count, longest run and sticky overflow.
    // A synchronous clr wins over any update in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt  <= '0;
            max_len  <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            evt_cnt  <= '0;
            max_len  <= '0;
            overflow <= 1'b0;
        end else begin
            if (rise && (evt_cnt != CNT_MAX)) begin
                evt_cnt <= evt_cnt + CNT_W'(1);
            end
            if ((state == HIGH) && fall && (run_len > max_len)) begin
                max_len <= run_len;
            end
            if ((state == REPORT) && rise && !rpt_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_bexp_y_tracker.sv
// Directed testbench for bexp_y_tracker. It runs a main instance
// (LEN_W=8) and a narrow instance (LEN_W=4) that share the same stimulus.
// The narrow instance is only checked for run-length saturation.
// Inputs change 1 ns after the rising edge, and outputs are sampled there too.

module tb_bexp_y_tracker;

`ifdef BEXP_TRACK_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HIGH   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       y_in;
    logic       clr;
    logic       rpt_ready;

    logic       y_q, rise_pulse, fall_pulse, rpt_valid, overflow;
    logic [7:0] evt_cnt, run_len, max_len, rpt_len;
    logic [1:0] state_dbg;

    logic       y_q4, rise_pulse4, fall_pulse4, rpt_valid4, overflow4;
    logic [7:0] evt_cnt4;
    logic [3:0] run_len4, max_len4, rpt_len4;
    logic [1:0] state_dbg4;

    int checks = 0;
    int errors = 0;

    bexp_y_tracker #(.CNT_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .y_in(y_in), .clr(clr),
        .y_q(y_q), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .evt_cnt(evt_cnt), .run_len(run_len), .max_len(max_len),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_len(rpt_len),
        .overflow(overflow), .state_dbg(state_dbg)
    );

    bexp_y_tracker #(.CNT_W(8), .LEN_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .y_in(y_in), .clr(clr),
        .y_q(y_q4), .rise_pulse(rise_pulse4), .fall_pulse(fall_pulse4),
        .evt_cnt(evt_cnt4), .run_len(run_len4), .max_len(max_len4),
        .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready), .rpt_len(rpt_len4),
        .overflow(overflow4), .state_dbg(state_dbg4)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; y_in = 1'b0; clr = 1'b0; rpt_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Drivers / scenarios
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; y_in = 1'b1; clr = 1'b0; rpt_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({y_q, rise_pulse, fall_pulse, rpt_valid, overflow} !== 5'b0 ||
            evt_cnt !== 8'd0 || run_len !== 8'd0 || max_len !== 8'd0 ||
            rpt_len !== 8'd0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: y_q=%0b rp=%0b fp=%0b v=%0b ov=%0b cnt=%0d run=%0d max=%0d rl=%0d st=%0d, required all 0",
                     y_q, rise_pulse, fall_pulse, rpt_valid, overflow, evt_cnt, run_len, max_len, rpt_len, state_dbg);
        end
        rst_n = 1'b1;
        repeat (SYNC_LAT) tick();
        tick();
        checks++;
        if (rise_pulse !== 1'b1) begin errors++; $display("FAIL reset_rise_pulse: got %0b required 1", rise_pulse); end
        checks++;
        if (evt_cnt !== 8'd1) begin errors++; $display("FAIL reset_evt_cnt: got %0d required 1", evt_cnt); end
        checks++;
        if (state_dbg !== ST_HIGH || run_len !== 8'd1) begin
            errors++; $display("FAIL reset_enter_high: st=%0d run=%0d required st=1 run=1", state_dbg, run_len);
        end
        tick();
        checks++;
        if (rise_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse_width: got %0b required 0", rise_pulse); end
    endtask

    task automatic test_run_measure();
        int v_cycles = 0, f_cycles = 0, first = -1;
        logic [7:0] seen_len = 8'd0;
        do_reset();
        rpt_ready = 1'b1;
        y_in = 1'b1;
        repeat (5) tick();
        y_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rpt_valid) begin
                v_cycles++;
                seen_len = rpt_len;
                if (first < 0) first = i;
            end
            if (fall_pulse) f_cycles++;
        end
        checks++;
        if (v_cycles != 1) begin errors++; $display("FAIL run_valid_cycles: got %0d required 1", v_cycles); end
        checks++;
        if (seen_len !== 8'd5) begin errors++; $display("FAIL run_rpt_len: got %0d required 5", seen_len); end
        checks++;
        if (first != SYNC_LAT) begin errors++; $display("FAIL run_latency: got %0d required %0d", first, SYNC_LAT); end
        checks++;
        if (max_len !== 8'd5) begin errors++; $display("FAIL run_max_len: got %0d required 5", max_len); end
        checks++;
        if (f_cycles != 1) begin errors++; $display("FAIL run_fall_pulses: got %0d required 1", f_cycles); end
        checks++;
        if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL run_back_idle: got %0d required 0", state_dbg); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rpt_ready = 1'b0;
        y_in = 1'b1;
        repeat (3) tick();
        y_in = 1'b0;
        repeat (SYNC_LAT + 1) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rpt_valid !== 1'b1 || rpt_len !== 8'd3) begin
                errors++; $display("FAIL bp_stall_%0d: valid=%0b len=%0d required valid=1 len=3", i, rpt_valid, rpt_len);
            end
            tick();
        end
        y_in = 1'b1;
        repeat (SYNC_LAT + 1) tick();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %0b required 1", overflow); end
        checks++;
        if (evt_cnt !== 8'd2) begin errors++; $display("FAIL bp_evt_cnt: got %0d required 2", evt_cnt); end
        checks++;
        if (rpt_valid !== 1'b1 || rpt_len !== 8'd3 || state_dbg !== ST_REPORT) begin
            errors++; $display("FAIL bp_still_pending: valid=%0b len=%0d st=%0d required 1/3/2", rpt_valid, rpt_len, state_dbg);
        end
        rpt_ready = 1'b1;
        tick();
        checks++;
        if (rpt_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %0b required 0", rpt_valid); end
        checks++;
        if (state_dbg !== ST_IDLE || overflow !== 1'b1) begin
            errors++; $display("FAIL bp_idle_sticky: st=%0d ov=%0b required 0/1", state_dbg, overflow);
        end
        y_in = 1'b0;
        repeat (SYNC_LAT + 2) tick();
    endtask

    task automatic test_enable_gating();
        logic [7:0] seen_len = 8'd0;
        do_reset();
        rpt_ready = 1'b1;
        for (int i = 0; i < 6 + SYNC_LAT; i++) begin
            y_in = (i < 6);
            en = !((i == 2 + SYNC_LAT) || (i == 3 + SYNC_LAT));
            tick();
        end
        y_in = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rpt_valid) seen_len = rpt_len;
        end
        checks++;
        if (seen_len !== 8'd4) begin errors++; $display("FAIL gate_rpt_len: got %0d required 4", seen_len); end
        checks++;
        if (run_len !== 8'd4) begin errors++; $display("FAIL gate_run_len_hold: got %0d required 4", run_len); end
    endtask

    task automatic test_saturation();
        logic [7:0] seen8 = 8'd0;
        logic [3:0] seen4 = 4'd0;
        do_reset();
        rpt_ready = 1'b1;
        y_in = 1'b1;
        repeat (20) tick();
        y_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rpt_valid) seen8 = rpt_len;
            if (rpt_valid4) seen4 = rpt_len4;
        end
        checks++;
        if (seen4 !== 4'd15) begin errors++; $display("FAIL sat_len4: got %0d required 15", seen4); end
        checks++;
        if (seen8 !== 8'd20) begin errors++; $display("FAIL sat_len8_nosat: got %0d required 20", seen8); end
        checks++;
        if (max_len4 !== 4'd15) begin errors++; $display("FAIL sat_max4: got %0d required 15", max_len4); end
    endtask

    task automatic test_clr_rise();
        do_reset();
        rpt_ready = 1'b0;
        y_in = 1'b1;
        repeat (2) tick();
        y_in = 1'b0;
        repeat (SYNC_LAT + 2) tick();
        y_in = 1'b1;
        repeat (SYNC_LAT + 1) tick();
        rpt_ready = 1'b1;
        y_in = 1'b0;
        repeat (SYNC_LAT + 3) tick();
        checks++;
        if (evt_cnt !== 8'd2 || overflow !== 1'b1 || max_len !== 8'd2 || state_dbg !== ST_IDLE) begin
            errors++; $display("FAIL clr_setup: cnt=%0d ov=%0b max=%0d st=%0d required 2/1/2/0", evt_cnt, overflow, max_len, state_dbg);
        end
        y_in = 1'b1;
        repeat (SYNC_LAT) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (evt_cnt !== 8'd0 || overflow !== 1'b0 || max_len !== 8'd0) begin
            errors++; $display("FAIL clr_stats: cnt=%0d ov=%0b max=%0d required 0/0/0", evt_cnt, overflow, max_len);
        end
        checks++;
        if (state_dbg !== ST_HIGH || run_len !== 8'd1) begin
            errors++; $display("FAIL clr_fsm: st=%0d run=%0d required 1/1", state_dbg, run_len);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rpt_ready = 1'b0;
        y_in = 1'b1;
        repeat (2) tick();
        y_in = 1'b0;
        repeat (SYNC_LAT + 2) tick();
        y_in = 1'b1;
        repeat (SYNC_LAT) tick();
        rpt_ready = 1'b1;
        tick();
        checks++;
        if (state_dbg !== ST_HIGH || run_len !== 8'd1 || rpt_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_direct_high: st=%0d run=%0d v=%0b required 1/1/0", state_dbg, run_len, rpt_valid);
        end
        checks++;
        if (evt_cnt !== 8'd2 || overflow !== 1'b0) begin
            errors++; $display("FAIL b2b_stats: cnt=%0d ov=%0b required 2/0", evt_cnt, overflow);
        end
    endtask

    task automatic test_sync_latency();
        int lat = -1;
        do_reset();
        y_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rise_pulse && lat < 0) lat = i;
        end
        checks++;
        if (lat != 1 + SYNC_LAT) begin errors++; $display("FAIL sync_rise_latency: got %0d required %0d", lat, 1 + SYNC_LAT); end
    endtask

    initial begin
        test_reset();
        test_run_measure();
        test_backpressure();
        test_enable_gating();
        test_saturation();
        test_clr_rise();
        test_back_to_back();
        test_sync_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
